// File: rtl/alu_pkg.sv
// Shared ALU definitions: data widths and operation codes.
// The ALU control unit imports this package as well.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd11,
    ALU_NOR  = 4'd12
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the datapath and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0]  firstOperand;
  logic [DATA_W-1:0]  secondOperand;
  logic [OP_W-1:0]    aluControlInput;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  output1;
  logic               zero;

  modport master (
    output firstOperand, secondOperand, aluControlInput, shamt,
    input  output1, zero
  );

  modport slave (
    input  firstOperand, secondOperand, aluControlInput, shamt,
    output output1, zero
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU result and zero-flag computation.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               result_zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_NOR:  result = ~(a | b);
      default:  result = '0;
    endcase
  end

  assign result_zero = (result == '0);

endmodule

// File: rtl/alu.sv
// MIPS ALU: combinational core followed by a result/zero register
// with synchronous active-low reset (reset leaves zero = 1).
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rstN,
  alu_if.slave  bus
);

  logic [DATA_W-1:0] core_result;
  logic              core_zero;

  alu_core u_core (
    .a           (bus.firstOperand),
    .b           (bus.secondOperand),
    .op          (bus.aluControlInput),
    .shamt       (bus.shamt),
    .result      (core_result),
    .result_zero (core_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      bus.output1 <= '0;
      bus.zero    <= 1'b1;
    end else begin
      bus.output1 <= core_result;
      bus.zero    <= core_zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written
// pipeline/reset sequences, and random ops against a reference model.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  alu_if bus ();

  alu dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] exp_o;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  // Reference: modular arithmetic on wide integers, shifts as powers of two.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [4:0] sh);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned pw = 64'd1 << sh;
    longint unsigned r;
    int sa = int'(a);
    int sb = int'(b);
    case (op)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd2:  r = (ua + ub) % 64'h1_0000_0000;
      4'd3:  r = (ub * pw) % 64'h1_0000_0000;
      4'd4:  r = ub / pw;
      4'd6:  r = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000;
      4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd11: r = (ua < ub) ? 64'd1 : 64'd0;
      4'd12: r = 64'h0000_0000_FFFF_FFFF ^ (ua | ub);
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] sh);
    bus.firstOperand    = a;
    bus.secondOperand   = b;
    bus.aluControlInput = op;
    bus.shamt           = sh;
  endtask

  task automatic check(input string name, input logic [31:0] exp_o, input logic exp_z);
    checks++;
    if (bus.output1 !== exp_o) begin
      errors++;
      $display("FAIL %s output1 got %h expected %h", name, bus.output1, exp_o);
    end
    checks++;
    if (bus.zero !== exp_z) begin
      errors++;
      $display("FAIL %s zero got %b expected %b", name, bus.zero, exp_z);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra, rb, rexp;
  logic [3:0]  rop;
  logic [4:0]  rsh;

  initial begin
    // A = 10, B = -20
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd0,  5'd7,  32'd8,          1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd1,  5'd7,  32'hFFFF_FFEE,  1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd12, 5'd7,  32'd17,         1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd2,  5'd3,  32'hFFFF_FFF6,  1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd6,  5'd3,  32'd30,         1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd7,  5'd3,  32'd0,          1'b1});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd11, 5'd3,  32'd1,          1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd3,  5'd1,  32'hFFFF_FFD8,  1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd4,  5'd1,  32'h7FFF_FFF6,  1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd4,  5'd31, 32'd1,          1'b0});
    vecs.push_back('{32'd10, 32'hFFFF_FFEC, 4'd3,  5'd0,  32'hFFFF_FFEC,  1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,  4'd2,  5'd0,  32'h8000_0000,  1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,  4'd5,  5'd2,  32'd0,          1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,  4'd15, 5'd2,  32'd0,          1'b1});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1,  4'd9,  5'd2,  32'd0,          1'b1});
    vecs.push_back('{32'h8000_0000, 32'd1,  4'd7,  5'd0,  32'd1,          1'b0});
    vecs.push_back('{32'h8000_0000, 32'd1,  4'd11, 5'd0,  32'd0,          1'b1});

    // Reset held two cycles with non-trivial inputs
    rstN = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 4'd2, 5'd4);
    tick();
    check("reset_c1", 32'd0, 1'b1);
    tick();
    check("reset_c2", 32'd0, 1'b1);
    rstN = 1'b1;
    drive(32'd10, 32'd10, 4'd6, 5'd0);
    tick();
    check("post_reset_sub", 32'd0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sh);
      tick();
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].exp_o, vecs[i].exp_z);
    end

    // Back-to-back ADD, SUB, AND
    drive(32'd100, 32'd58, 4'd2, 5'd0);
    tick();
    check("pipe_add", 32'd158, 1'b0);
    drive(32'd100, 32'd58, 4'd6, 5'd0);
    tick();
    check("pipe_sub", 32'd42, 1'b0);
    drive(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 5'd0);
    tick();
    check("pipe_and", 32'h00F0_00F0, 1'b0);

    // Same stream with reset asserted during the SUB cycle
    drive(32'd100, 32'd58, 4'd2, 5'd0);
    tick();
    check("rst_add", 32'd158, 1'b0);
    drive(32'd100, 32'd58, 4'd6, 5'd0);
    rstN = 1'b0;
    tick();
    check("rst_sub", 32'd0, 1'b1);
    rstN = 1'b1;
    drive(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 5'd0);
    tick();
    check("rst_and", 32'h00F0_00F0, 1'b0);

    // Inputs wiggling between edges: only the pre-edge value counts
    drive(32'd1, 32'd1, 4'd2, 5'd0);
    #3;
    drive(32'd5, 32'd6, 4'd2, 5'd0);
    tick();
    check("late_change", 32'd11, 1'b0);

    for (int unsigned n = 0; n < 400; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      if (n % 8 == 0) rb = ra;
      rop = 4'($urandom_range(0, 15));
      rsh = 5'($urandom_range(0, 31));
      drive(ra, rb, rop, rsh);
      rexp = model(ra, rb, rop, rsh);
      tick();
      check($sformatf("rand%0d_op%0d", n, rop), rexp, (rexp == 32'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
